color_reduce_pipe: RTL and testbench
====================================

# color_reduce_pipe

Parametrised, streaming successor to the HSV colour-reduction path. It quantises each RGB channel to a runtime-selectable number of retained bits, with truncate, round or 4x4 ordered-dither modes. Pixel position is tracked from frame and line markers, and the block adds valid/ready flow control. It sits between the video source and the display/encoder path. New settings take effect only at frame boundaries, so a frame never mixes quantisation settings.

## Interface
- CW, 8: bits per colour channel (4..15).
- XW, 11: width of internal x/y position counters.
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- cfg_we  in  1  config write strobe, one write per cycle.
- cfg_sel  in  2  target: 0=R keep, 1=G keep, 2=B keep, 3=mode.
- cfg_data  in  4  keep-bit count (0..CW, values >CW clamp to CW); for mode, bits[1:0].
- in_valid  in  1  input pixel valid.
- in_ready  out  1  block accepts input this cycle.
- in_sof  in  1  first pixel of frame (qualified by in_valid).
- in_eol  in  1  last pixel of line.
- in_rgb  in  3*CW  {R,G,B}, R in MSBs.
- out_valid  out  1  output pixel valid.
- out_ready  in  1  downstream accepts.
- out_sof, out_eol  out  1 each  markers aligned with out_rgb.
- out_rgb  out  3*CW  reduced {R,G,B}.

## Operation
- Shadow registers: keep_r/g/b and mode, written by cfg_we. Active registers copy the shadows when an in_sof pixel is accepted, and that pixel is the first one to use them. If cfg_we and an accepted sof occur in the same cycle, the written value is loaded into the active register (write wins).
- Modes:
  - 0 = bypass.
  - 1 = truncate.
  - 2 = round.
  - 3 = dither.
- Per channel, with drop = CW-keep:
  - keep=CW or mode 0: value passes unchanged.
  - keep=0: channel outputs 0.
  - Truncate: clear the low drop bits.
  - Round: add 1<<(drop-1), saturating at 2^CW-1, then clear the low drop bits.
  - Dither: take d = Bayer[y[1:0]][x[1:0]] from rows {0,8,2,10}, {12,4,14,6}, {3,11,1,9}, {15,7,13,5}. Scale it to d<<(drop-4) if drop≥4, else d>>(4-drop). Add it saturating, then clear the low drop bits.
- Position counters:
  - An accepted sof pixel is given x=0, y=0.
  - Each accepted pixel increments x. An accepted eol pixel sets x to 0 and increments y.
  - Both counters wrap at 2^XW with no error.
  - Counters advance only on in_valid && in_ready.
- Without a sof after reset, active settings stay at reset values: bypass, keep=CW.

## Timing
- Two register stages:
  - S1 registers the pixel, markers, x/y and the per-channel offsets.
  - S2 registers the saturated, masked result.
- Global advance: en = out_ready || !out_valid. in_ready = en (combinational). Bubbles advance while en=1.
- Latency is 2 cycles from input acceptance to out_valid, with out_ready held high. Throughput is 1 pixel/cycle.
- While out_valid && !out_ready: out_rgb, out_sof and out_eol hold stable, in_ready=0, and S1 holds.
- Reset (asserted low, at any time including mid-frame) forces all of the following immediately:
  - out_valid=0, out_rgb=0, out_sof=0, out_eol=0.
  - Both stage valids=0; x=y=0.
  - Shadow and active mode=0; keeps=CW.
  - In-flight pixels are discarded.
- in_ready is 1 during reset.

## Test plan
- Bypass: after reset, stream 0x123456 (CW=8), out_ready=1 -> out_valid at cycle +2 with out_rgb=0x123456.
- Truncate: mode=1, keeps=3; sof pixel 0xFF7F01 -> 0xE06000. Keep=0 on G -> G=0x00.
- Round: mode=2, keeps=4; R=0x78 -> 0x80; R=0xFF -> 0xF0 (saturated).
- Dither: mode=3, keeps=4; line of 0x777777 starting with sof -> x=0 gives 0x707070, x=3 gives 0x808080. Second line, x=0 (d=12) -> 0x808080.
- Shadow timing: write keep_r=2 mid-frame -> the remaining pixels of that frame are unchanged; the next sof pixel uses keep 2. Write on the same cycle as the sof accept -> the new value applies to that sof pixel.
- Backpressure/reset: hold out_ready=0 for 5 cycles -> out_rgb stable, in_ready=0, no pixel lost or duplicated. Assert reset with 2 pixels in flight -> out_valid=0 at once, and a following frame starts with x=y=0.

Source files
------------

// File: rtl/color_reduce_pipe.sv
// rtl/color_reduce_pipe.sv - two-stage RGB quantiser with truncate/round/ordered-dither modes
// Settings are shadowed and applied on the accepted start-of-frame pixel.
module color_reduce_pipe #(
  parameter int CW = 8,
  parameter int XW = 11
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_cfg_we,
  input  logic [1:0]      i_cfg_sel,
  input  logic [3:0]      i_cfg_data,
  input  logic            i_in_valid,
  output logic            o_in_ready,
  input  logic            i_in_sof,
  input  logic            i_in_eol,
  input  logic [3*CW-1:0] i_in_rgb,
  output logic            o_out_valid,
  input  logic            i_out_ready,
  output logic            o_out_sof,
  output logic            o_out_eol,
  output logic [3*CW-1:0] o_out_rgb
);

  localparam logic [3:0] KMAX = 4'(CW);

  // Channel index 2 = R, 1 = G, 0 = B, matching the rgb slice order.
  logic [2:0][3:0]    r_sh_keep, r_act_keep, w_nx_keep, w_use_keep;
  logic [1:0]         r_sh_mode, r_act_mode, w_nx_mode, w_use_mode;
  logic [3:0]         w_clamp, w_d;
  logic [XW-1:0]      r_x, r_y, w_x, w_y;
  logic               w_en, w_acc, w_sof_acc;
  logic [2:0][CW-1:0] w_off, w_mask, w_res;
  logic [2:0][CW:0]   w_sum;

  logic               r_s1_valid, r_s1_sof, r_s1_eol;
  logic [3*CW-1:0]    r_s1_rgb;
  logic [2:0][CW-1:0] r_s1_off, r_s1_mask;
  logic               r_s2_valid, r_s2_sof, r_s2_eol;
  logic [3*CW-1:0]    r_s2_rgb;

  function automatic logic [3:0] f_bayer(input logic [1:0] y, input logic [1:0] x);
    logic [3:0] l_d;
    l_d = 4'd0;
    case ({y, x})
      4'h0: l_d = 4'd0;   4'h1: l_d = 4'd8;  4'h2: l_d = 4'd2;  4'h3: l_d = 4'd10;
      4'h4: l_d = 4'd12;  4'h5: l_d = 4'd4;  4'h6: l_d = 4'd14; 4'h7: l_d = 4'd6;
      4'h8: l_d = 4'd3;   4'h9: l_d = 4'd11; 4'hA: l_d = 4'd1;  4'hB: l_d = 4'd9;
      4'hC: l_d = 4'd15;  4'hD: l_d = 4'd7;  4'hE: l_d = 4'd13; 4'hF: l_d = 4'd5;
    endcase
    return l_d;
  endfunction

  // Mode 0 keeps every bit; otherwise the low (CW-keep) bits are cleared.
  function automatic logic [CW-1:0] f_mask(input logic [3:0] keep, input logic [1:0] mode);
    logic [CW:0] l_m;
    l_m = {(CW+1){1'b1}} << (CW - int'(keep));
    if (mode == 2'd0) l_m = {(CW+1){1'b1}};
    return l_m[CW-1:0];
  endfunction

  function automatic logic [CW-1:0] f_off(input logic [3:0] keep, input logic [1:0] mode,
                                          input logic [3:0] d);
    int            l_drop;
    logic [CW:0]   l_h;
    logic [CW+3:0] l_d;
    logic [CW-1:0] l_off;
    l_drop = CW - int'(keep);
    l_off  = '0;
    l_h    = '0;
    l_d    = (CW+4)'(d);
    if (mode == 2'd2 && l_drop > 0) begin
      l_h   = (CW+1)'(1) << (l_drop - 1);
      l_off = l_h[CW-1:0];
    end else if (mode == 2'd3 && l_drop > 0) begin
      if (l_drop >= 4) l_d = l_d << (l_drop - 4);
      else             l_d = l_d >> (4 - l_drop);
      l_off = l_d[CW-1:0];
    end
    return l_off;
  endfunction

  assign w_en       = i_out_ready || !r_s2_valid;
  assign o_in_ready = w_en;
  assign w_acc      = i_in_valid && w_en;
  assign w_sof_acc  = w_acc && i_in_sof;

  always_comb begin
    w_clamp   = (i_cfg_data > KMAX) ? KMAX : i_cfg_data;
    w_nx_keep = r_sh_keep;
    w_nx_mode = r_sh_mode;
    if (i_cfg_we) begin
      case (i_cfg_sel)
        2'd0:    w_nx_keep[2] = w_clamp;
        2'd1:    w_nx_keep[1] = w_clamp;
        2'd2:    w_nx_keep[0] = w_clamp;
        default: w_nx_mode    = i_cfg_data[1:0];
      endcase
    end
    // A same-cycle write reaches the sof pixel through the next-shadow value.
    w_use_keep = w_sof_acc ? w_nx_keep : r_act_keep;
    w_use_mode = w_sof_acc ? w_nx_mode : r_act_mode;
    w_x        = i_in_sof ? '0 : r_x;
    w_y        = i_in_sof ? '0 : r_y;
    w_d        = f_bayer(w_y[1:0], w_x[1:0]);
    for (int c = 0; c < 3; c++) begin
      w_off[c]  = f_off(w_use_keep[c], w_use_mode, w_d);
      w_mask[c] = f_mask(w_use_keep[c], w_use_mode);
      w_sum[c]  = {1'b0, r_s1_rgb[c*CW +: CW]} + {1'b0, r_s1_off[c]};
      w_res[c]  = (w_sum[c][CW] ? {CW{1'b1}} : w_sum[c][CW-1:0]) & r_s1_mask[c];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sh_keep  <= {3{KMAX}};
      r_act_keep <= {3{KMAX}};
      r_sh_mode  <= 2'd0;
      r_act_mode <= 2'd0;
      r_x        <= '0;
      r_y        <= '0;
    end else begin
      r_sh_keep <= w_nx_keep;
      r_sh_mode <= w_nx_mode;
      if (w_sof_acc) begin
        r_act_keep <= w_nx_keep;
        r_act_mode <= w_nx_mode;
      end
      if (w_acc) begin
        if (i_in_eol) begin
          r_x <= '0;
          r_y <= w_y + 1'b1;
        end else begin
          r_x <= w_x + 1'b1;
          r_y <= w_y;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_sof   <= 1'b0;
      r_s1_eol   <= 1'b0;
      r_s1_rgb   <= '0;
      r_s1_off   <= '0;
      r_s1_mask  <= '0;
      r_s2_valid <= 1'b0;
      r_s2_sof   <= 1'b0;
      r_s2_eol   <= 1'b0;
      r_s2_rgb   <= '0;
    end else if (w_en) begin
      r_s1_valid <= i_in_valid;
      r_s1_sof   <= i_in_sof;
      r_s1_eol   <= i_in_eol;
      r_s1_rgb   <= i_in_rgb;
      r_s1_off   <= w_off;
      r_s1_mask  <= w_mask;
      r_s2_valid <= r_s1_valid;
      r_s2_sof   <= r_s1_sof;
      r_s2_eol   <= r_s1_eol;
      r_s2_rgb   <= w_res;
    end
  end

  assign o_out_valid = r_s2_valid;
  assign o_out_sof   = r_s2_sof;
  assign o_out_eol   = r_s2_eol;
  assign o_out_rgb   = r_s2_rgb;

endmodule

// File: tb/tb_color_reduce_pipe.sv
// tb/tb_color_reduce_pipe.sv - directed and random checks of color_reduce_pipe against a reference model
module tb_color_reduce_pipe;
  localparam int CW = 8;
  localparam int XW = 11;
  localparam int BAY [16] = '{0, 8, 2, 10, 12, 4, 14, 6, 3, 11, 1, 9, 15, 7, 13, 5};

  logic            clk = 1'b0;
  logic            rst_n;
  logic            cfg_we;
  logic [1:0]      cfg_sel;
  logic [3:0]      cfg_data;
  logic            in_valid, in_ready, in_sof, in_eol;
  logic [3*CW-1:0] in_rgb;
  logic            out_valid, out_ready, out_sof, out_eol;
  logic [3*CW-1:0] out_rgb;

  always #5 clk = ~clk;

  color_reduce_pipe #(.CW(CW), .XW(XW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_cfg_we(cfg_we), .i_cfg_sel(cfg_sel), .i_cfg_data(cfg_data),
    .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_sof(in_sof), .i_in_eol(in_eol),
    .i_in_rgb(in_rgb), .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_sof(out_sof),
    .o_out_eol(out_eol), .o_out_rgb(out_rgb)
  );

  int checks = 0;
  int failures = 0;
  int sh_keep [3];
  int act_keep [3];
  int sh_mode, act_mode, mx, my, n_acc, n_out;
  logic [3*CW+1:0] exp_q [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic int ref_ch(int v, int keep, int mode, int x, int y);
    int drop, q, off, s;
    if (mode == 0 || keep == CW) return v;
    if (keep == 0) return 0;
    drop = CW - keep;
    q = 1 << drop;
    if (mode == 1)      off = 0;
    else if (mode == 2) off = q / 2;
    else                off = (BAY[(y % 4) * 4 + (x % 4)] * q) / 16;
    s = v + off;
    if (s > (1 << CW) - 1) s = (1 << CW) - 1;
    return (s / q) * q;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 3; c++) begin
      sh_keep[c] = CW;
      act_keep[c] = CW;
    end
    sh_mode = 0; act_mode = 0; mx = 0; my = 0;
    exp_q.delete();
  endtask

  task automatic model_cfg(input logic [1:0] sel, input logic [3:0] data);
    if (sel == 2'd3) sh_mode = int'(data[1:0]);
    else sh_keep[sel] = (int'(data) > CW) ? CW : int'(data);
  endtask

  task automatic model_pixel(input logic sof, input logic eol, input logic [3*CW-1:0] rgb);
    logic [3*CW-1:0] o;
    if (sof) begin
      act_keep = sh_keep;
      act_mode = sh_mode;
      mx = 0; my = 0;
    end
    for (int c = 0; c < 3; c++)
      o[(2-c)*CW +: CW] = CW'(ref_ch(int'(rgb[(2-c)*CW +: CW]), act_keep[c], act_mode, mx, my));
    exp_q.push_back({sof, eol, o});
    n_acc++;
    if (eol) begin mx = 0; my = (my + 1) % (1 << XW); end
    else mx = (mx + 1) % (1 << XW);
  endtask

  task automatic step(input logic v, input logic sof, input logic eol, input logic [3*CW-1:0] rgb,
                      input logic we, input logic [1:0] sel, input logic [3:0] data,
                      input logic ordy, output logic acc);
    logic [3*CW+1:0] e;
    in_valid = v; in_sof = sof; in_eol = eol; in_rgb = rgb;
    cfg_we = we; cfg_sel = sel; cfg_data = data; out_ready = ordy;
    #1;
    if (out_valid && ordy) begin
      if (exp_q.size() == 0) chk("out_unexpected", out_valid, 1'b0);
      else begin
        e = exp_q.pop_front();
        chk("out_rgb", out_rgb, e[3*CW-1:0]);
        chk("out_sof", out_sof, e[3*CW+1]);
        chk("out_eol", out_eol, e[3*CW]);
        n_out++;
      end
    end else if (out_valid) begin
      chk("stall_in_ready", in_ready, 1'b0);
      if (exp_q.size() > 0) chk("hold_rgb", out_rgb, exp_q[0][3*CW-1:0]);
    end
    acc = v && in_ready;
    if (we) model_cfg(sel, data);
    if (acc) model_pixel(sof, eol, rgb);
    @(posedge clk); #1;
    in_valid = 1'b0; cfg_we = 1'b0;
  endtask

  task automatic idle(input int n, input logic ordy);
    logic acc;
    for (int i = 0; i < n; i++) step(0, 0, 0, '0, 0, 2'd0, 4'd0, ordy, acc);
  endtask

  task automatic cfg(input logic [1:0] sel, input logic [3:0] data);
    logic acc;
    step(0, 0, 0, '0, 1, sel, data, 1, acc);
  endtask

  task automatic send(input logic sof, input logic eol, input logic [3*CW-1:0] rgb, input logic we,
                      input logic [1:0] sel, input logic [3:0] data, input logic ordy);
    logic acc;
    int n;
    acc = 0; n = 0;
    while (!acc && n < 50) begin
      step(1, sof, eol, rgb, we && (n == 0), sel, data, ordy, acc);
      n++;
    end
    if (!acc) chk("send_timeout", acc, 1'b1);
  endtask

  task automatic send_expect(input string tag, input logic sof, input logic eol,
                             input logic [3*CW-1:0] rgb, input logic we, input logic [1:0] sel,
                             input logic [3:0] data, input logic [3*CW-1:0] expv);
    send(sof, eol, rgb, we, sel, data, 1);
    idle(1, 1);
    chk({tag, "_valid"}, out_valid, 1'b1);
    chk(tag, out_rgb, expv);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic acc, pend, v, we, sof, eol, ordy;
    logic [1:0] sel;
    logic [3:0] data;
    logic [3*CW-1:0] rgb;
    n_acc = 0; n_out = 0;
    model_reset();
    rst_n = 0; cfg_we = 0; cfg_sel = 0; cfg_data = 0;
    in_valid = 0; in_sof = 0; in_eol = 0; in_rgb = '0; out_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_rgb", out_rgb, '0);
    chk("rst_in_ready", in_ready, 1'b1);
    #3 rst_n = 1;
    @(posedge clk); #1;

    step(1, 1, 0, 24'h123456, 0, 2'd0, 4'd0, 1, acc);
    chk("lat1_valid", out_valid, 1'b0);
    idle(1, 1);
    chk("lat2_valid", out_valid, 1'b1);
    chk("bypass_rgb", out_rgb, 24'h123456);

    cfg(2'd3, 4'd1); cfg(2'd0, 4'd3); cfg(2'd1, 4'd3); cfg(2'd2, 4'd3);
    send_expect("trunc", 1, 0, 24'hFF7F01, 0, 2'd0, 4'd0, 24'hE06000);
    cfg(2'd1, 4'd0);
    send_expect("trunc_g0", 1, 0, 24'hFF7F01, 0, 2'd0, 4'd0, 24'hE00000);

    cfg(2'd3, 4'd2); cfg(2'd0, 4'd4); cfg(2'd1, 4'd4); cfg(2'd2, 4'd4);
    send_expect("round", 1, 0, 24'h78FF00, 0, 2'd0, 4'd0, 24'h80F000);

    cfg(2'd3, 4'd3);
    send_expect("dith_x0", 1, 0, 24'h777777, 0, 2'd0, 4'd0, 24'h707070);
    send_expect("dith_x1", 0, 0, 24'h777777, 0, 2'd0, 4'd0, 24'h707070);
    send_expect("dith_x2", 0, 0, 24'h777777, 0, 2'd0, 4'd0, 24'h707070);
    send_expect("dith_x3", 0, 1, 24'h777777, 0, 2'd0, 4'd0, 24'h808080);
    send_expect("dith_y1x0", 0, 0, 24'h777777, 0, 2'd0, 4'd0, 24'h808080);

    cfg(2'd3, 4'd1); cfg(2'd0, 4'd8); cfg(2'd1, 4'd8); cfg(2'd2, 4'd15);
    send_expect("shadow_sof", 1, 0, 24'hFFFFFF, 0, 2'd0, 4'd0, 24'hFFFFFF);
    send_expect("shadow_mid", 0, 0, 24'hFFFFFF, 1, 2'd0, 4'd2, 24'hFFFFFF);
    send_expect("shadow_mid2", 0, 0, 24'hFFFFFF, 0, 2'd0, 4'd0, 24'hFFFFFF);
    send_expect("shadow_next", 1, 0, 24'hFFFFFF, 0, 2'd0, 4'd0, 24'hC0FFFF);
    send_expect("same_cycle", 1, 0, 24'hFFFFFF, 1, 2'd0, 4'd8, 24'hFFFFFF);

    cfg(2'd0, 4'd5);
    step(1, 1, 0, 24'hA1B2C3, 0, 2'd0, 4'd0, 0, acc);
    step(1, 0, 0, 24'h5F6E7D, 0, 2'd0, 4'd0, 0, acc);
    pend = 1;
    for (int i = 0; i < 5; i++) begin
      step(pend, 0, 1, 24'h3C4D5E, 0, 2'd0, 4'd0, 0, acc);
      if (acc) pend = 0;
    end
    chk("bp_in_ready", in_ready, 1'b0);
    chk("bp_out_valid", out_valid, 1'b1);
    if (pend) send(0, 1, 24'h3C4D5E, 0, 2'd0, 4'd0, 1);
    idle(4, 1);
    chk("bp_count", n_out, n_acc);
    chk("bp_queue", exp_q.size(), 0);

    step(1, 1, 0, 24'h111111, 0, 2'd0, 4'd0, 1, acc);
    step(1, 0, 0, 24'h222222, 0, 2'd0, 4'd0, 1, acc);
    out_ready = 0;
    #2 rst_n = 0;
    #1;
    chk("mid_rst_out_valid", out_valid, 1'b0);
    chk("mid_rst_out_rgb", out_rgb, '0);
    chk("mid_rst_out_sof", out_sof, 1'b0);
    chk("mid_rst_in_ready", in_ready, 1'b1);
    model_reset();
    n_acc = 0; n_out = 0;
    @(posedge clk); #2 rst_n = 1;
    @(posedge clk); #1;
    send_expect("post_rst_bypass", 0, 0, 24'hABCDEF, 0, 2'd0, 4'd0, 24'hABCDEF);
    cfg(2'd3, 4'd3); cfg(2'd0, 4'd4); cfg(2'd1, 4'd4); cfg(2'd2, 4'd4);
    send_expect("no_sof_bypass", 0, 0, 24'h777777, 0, 2'd0, 4'd0, 24'h777777);
    send_expect("post_rst_x0", 1, 0, 24'h777777, 0, 2'd0, 4'd0, 24'h707070);
    send_expect("post_rst_x1", 0, 0, 24'h777777, 0, 2'd0, 4'd0, 24'h707070);

    for (int i = 0; i < 600; i++) begin
      v    = ($urandom % 10) < 7;
      sof  = ($urandom % 16) == 0;
      eol  = ($urandom % 6) == 0;
      rgb  = 24'($urandom);
      we   = ($urandom % 4) == 0;
      sel  = 2'($urandom);
      data = 4'($urandom);
      ordy = ($urandom % 4) != 0;
      step(v, sof, eol, rgb, we, sel, data, ordy, acc);
    end
    idle(6, 1);
    chk("rand_count", n_out, n_acc);
    chk("rand_queue", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
